keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Scans a passive ROWS x COLS matrix keypad by driving one column low at a time and sampling the row lines. It debounces the full matrix and rejects multi-key presses. Each clean single-key press is delivered as a key code over a valid/ready handshake. It is the input-side counterpart of the multiplexed seven-segment display path and sits in the IO controller group next to it, feeding the CPU's memory-mapped IO.

Parameters:
ROWS, 4, number of row inputs (sensed lines)
COLS, 4, number of column outputs (driven lines)
CLK_PERIOD, 10, clock period in ns
SCAN_RATE, 1000, column strobe rate in Hz; COL_CLKS = (1000000000/SCAN_RATE)/CLK_PERIOD, minimum 4
DEBOUNCE_FRAMES, 4, consecutive identical full-matrix frames required before a change is accepted (>=2)
KEY_W, $clog2(ROWS*COLS), key code width

Ports:
clk_in  input  1  system clock
rst_low_in  input  1  reset; asynchronous, active-low
rows_in  input  ROWS  row sense lines, active-low, externally pulled up, asynchronous
cols_out  output  COLS  column drive, active-low, exactly one bit low while scanning
key_code_out  output  KEY_W  key code = row*COLS + col; held stable while key_valid_out=1
key_valid_out  output  1  key event available
key_ready_in  input  1  consumer accepts; transfer occurs on a cycle with valid=1 and ready=1
key_held_out  output  1  1 while the debounced matrix contains exactly one pressed key
overrun_out  output  1  one-cycle pulse: an event was dropped because valid was still pending

Behaviour:
- Reset (async assert, sync release): cols_out=all 1s, key_code_out=0, key_valid_out=0, key_held_out=0, overrun_out=0; column index=0, clock counter=0, frame/debounce state cleared, FSM=RELEASED.
- rows_in passes through a 2-flop synchronizer before use.
- Scan: the first cycle after reset release drives cols_out with bit 0 low. Column c stays low for COL_CLKS cycles. The synchronized rows are sampled on the last cycle of that window and captured as inverted row bits (1 = pressed) into the frame buffer slot for column c. The index then advances and wraps from COLS-1 to 0. Exactly one column is low at all times after reset.
- Frame: complete when column COLS-1 is sampled. Frame period = COLS*COL_CLKS cycles.
- Debounce: at frame completion, if the new frame equals the previous frame, increment stable_cnt (saturating). Otherwise clear it to 0. When stable_cnt reaches DEBOUNCE_FRAMES-1, the frame is copied into the debounced matrix. The first frame after reset never counts as stable.
- FSM, evaluated the cycle after each debounced-matrix update:
  RELEASED: 0 keys -> stay. Exactly 1 key -> PRESSED, raise event. >=2 keys -> MULTI, no event.
  PRESSED: the same single key -> stay. 0 keys -> RELEASED. Any other pattern -> MULTI, no event.
  MULTI: -> RELEASED only when 0 keys. Otherwise stay. Keys are never emitted from MULTI.
- key_held_out = (FSM==PRESSED).
- Event delivery:
  - If key_valid_out=0: key_code_out loads the code and key_valid_out goes 1 on the following cycle.
  - If key_valid_out=1 (pending): the new event is dropped, overrun_out pulses for 1 cycle, and key_code_out is unchanged.
  - key_valid_out clears the cycle after valid&&ready.
  - An accept and a new event in the same cycle: the event is delivered (valid stays 1, new code), with no overrun.
- Code ordering: lowest row, then lowest column wins. This ordering only matters for encoding, since only single keys are emitted.
- Press latency: from a stable press, at most (DEBOUNCE_FRAMES+1)*COLS*COL_CLKS + 4 cycles.
- rows_in changes mid-column are ignored until the sample cycle.
- Reset mid-scan aborts everything immediately. A pending event is lost.

Optional Feature:
KEYPAD_RELEASE_EVENT_EN:
- Defined: adds output key_release_out (1 bit, reset 0), qualified by key_valid_out. A PRESSED->RELEASED transition emits an event with the same key code and key_release_out=1. Press events carry key_release_out=0. Release events follow the same overrun rules.
- Undefined: the port is absent and releases generate no event.

Test Plan:
All scenarios use ROWS=4, COLS=4, CLK_PERIOD=10, SCAN_RATE=10000000 (COL_CLKS=10), DEBOUNCE_FRAMES=4.
1. Reset, no keys -> cols_out cycles 1110,1101,1011,0111 every 10 clocks; key_valid_out stays 0.
2. Model key row 2/col 1 pressed (rows_in[2] low when cols_out[1]=0), ready=1 -> one valid pulse with key_code_out=9 within 5*40+4 clocks; key_held_out=1.
3. Same key bounced, toggling every 15 clocks for 100 clocks, then stable -> exactly one event (code 9) after bouncing stops.
4. Keys 0 and 5 pressed together -> no event, overrun_out=0. Release all, then press key 15 -> one event, code 15.
5. ready=0, press/release key 3 then press key 4 -> valid held with code 3, overrun_out pulses once. Raise ready -> valid clears the next cycle.
6. Assert reset mid-event with valid=1 -> all outputs return to reset values asynchronously. With KEYPAD_RELEASE_EVENT_EN defined, a press/release of key 6 yields events (6, release=0) then (6, release=1).

Source files
------------

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column strobe, full-matrix debounce, multi-key rejection, valid/ready key events.
// Optional release events are enabled with `define KEYPAD_RELEASE_EVENT_EN (adds key_release_out).
//   state      | meaning
//   S_RELEASED | no key held, a single key press emits an event
//   S_PRESSED  | exactly one debounced key held
//   S_MULTI    | several keys seen, waits for all keys released
`timescale 1ns/1ps
module keypad_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int CLK_PERIOD      = 10,
  parameter int SCAN_RATE       = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int KEY_W           = $clog2(ROWS*COLS)
) (
  input  logic             clk_in,
  input  logic             rst_low_in,
  input  logic [ROWS-1:0]  rows_in,
  output logic [COLS-1:0]  cols_out,
  output logic [KEY_W-1:0] key_code_out,
  output logic             key_valid_out,
  input  logic             key_ready_in,
  output logic             key_held_out,
  output logic             overrun_out
`ifdef KEYPAD_RELEASE_EVENT_EN
  ,
  output logic             key_release_out
`endif
);

  localparam int COL_CLKS_RAW = (1000000000 / SCAN_RATE) / CLK_PERIOD;
  localparam int COL_CLKS     = (COL_CLKS_RAW < 4) ? 4 : COL_CLKS_RAW;
  localparam int NKEYS        = ROWS * COLS;
  localparam int CNT_W        = $clog2(COL_CLKS);
  localparam int COL_W        = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int STB_W        = $clog2(DEBOUNCE_FRAMES);
  localparam int POP_W        = $clog2(NKEYS + 1);

  typedef enum logic [1:0] {S_RELEASED, S_PRESSED, S_MULTI} state_t;

  logic [ROWS-1:0]  rows_meta, rows_sync;
  logic             scanning;
  logic [CNT_W-1:0] clk_cnt;
  logic [COL_W-1:0] col_idx;
  logic             sample_now, frame_done;
  logic [NKEYS-1:0] frame_cur, frame_next, frame_prev, deb_matrix;
  logic             frame_seen, deb_load, deb_upd;
  logic [STB_W-1:0] stable_cnt, stable_nxt;
  logic [POP_W-1:0] key_cnt;
  logic [KEY_W-1:0] low_code, held_code, ev_code;
  logic             ev;
`ifdef KEYPAD_RELEASE_EVENT_EN
  logic             ev_rel;
`endif
  state_t           state, state_nxt;

  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      rows_meta <= '1;
      rows_sync <= '1;
    end else begin
      rows_meta <= rows_in;
      rows_sync <= rows_meta;
    end
  end

  assign sample_now = scanning && (clk_cnt == CNT_W'(COL_CLKS - 1));
  assign frame_done = sample_now && (col_idx == COL_W'(COLS - 1));

  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      scanning <= 1'b0;
      clk_cnt  <= '0;
      col_idx  <= '0;
    end else if (!scanning) begin
      scanning <= 1'b1;
    end else if (sample_now) begin
      clk_cnt <= '0;
      col_idx <= frame_done ? '0 : col_idx + 1'b1;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  always_comb begin
    cols_out = '1;
    if (scanning) cols_out[col_idx] = 1'b0;
  end

  // Frame bits are indexed by key code (row*COLS + col), 1 = pressed.
  always_comb begin
    frame_next = frame_cur;
    for (int r = 0; r < ROWS; r++) frame_next[r*COLS + int'(col_idx)] = ~rows_sync[r];
  end

  always_comb begin
    stable_nxt = stable_cnt;
    if (!frame_seen || (frame_next != frame_prev)) stable_nxt = '0;
    else if (stable_cnt != STB_W'(DEBOUNCE_FRAMES - 1)) stable_nxt = stable_cnt + 1'b1;
  end

  // Load only on the frame that reaches the threshold, so each stable pattern updates once.
  assign deb_load = frame_done && (stable_nxt == STB_W'(DEBOUNCE_FRAMES - 1)) &&
                    (stable_cnt != STB_W'(DEBOUNCE_FRAMES - 1));

  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      frame_cur  <= '0;
      frame_prev <= '0;
      frame_seen <= 1'b0;
      stable_cnt <= '0;
      deb_matrix <= '0;
      deb_upd    <= 1'b0;
    end else begin
      if (sample_now) frame_cur <= frame_next;
      if (frame_done) begin
        frame_prev <= frame_next;
        frame_seen <= 1'b1;
        stable_cnt <= stable_nxt;
      end
      if (deb_load) deb_matrix <= frame_next;
      deb_upd <= deb_load;
    end
  end

  always_comb begin
    key_cnt  = '0;
    low_code = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (deb_matrix[i]) begin
        key_cnt  = key_cnt + 1'b1;
        low_code = KEY_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ev        = 1'b0;
    ev_code   = low_code;
`ifdef KEYPAD_RELEASE_EVENT_EN
    ev_rel    = 1'b0;
`endif
    if (deb_upd) begin
      case (state)
        S_RELEASED: begin
          if (key_cnt == POP_W'(1)) begin
            state_nxt = S_PRESSED;
            ev        = 1'b1;
          end else if (key_cnt != '0) begin
            state_nxt = S_MULTI;
          end
        end
        S_PRESSED: begin
          if (key_cnt == '0) begin
            state_nxt = S_RELEASED;
`ifdef KEYPAD_RELEASE_EVENT_EN
            ev        = 1'b1;
            ev_code   = held_code;
            ev_rel    = 1'b1;
`endif
          end else if (!(key_cnt == POP_W'(1) && low_code == held_code)) begin
            state_nxt = S_MULTI;
          end
        end
        S_MULTI: begin
          if (key_cnt == '0) state_nxt = S_RELEASED;
        end
        default: state_nxt = S_RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      state     <= S_RELEASED;
      held_code <= '0;
    end else begin
      state <= state_nxt;
      if (deb_upd && state == S_RELEASED) held_code <= low_code;
    end
  end

  assign key_held_out = (state == S_PRESSED);

  // An accept in the same cycle frees the slot, so a simultaneous event is delivered, not dropped.
  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      key_code_out    <= '0;
      key_valid_out   <= 1'b0;
      overrun_out     <= 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
      key_release_out <= 1'b0;
`endif
    end else begin
      overrun_out <= 1'b0;
      if (ev) begin
        if (!key_valid_out || key_ready_in) begin
          key_code_out    <= ev_code;
          key_valid_out   <= 1'b1;
`ifdef KEYPAD_RELEASE_EVENT_EN
          key_release_out <= ev_rel;
`endif
        end else begin
          overrun_out <= 1'b1;
        end
      end else if (key_valid_out && key_ready_in) begin
        key_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model, vector table and event scoreboard.
`timescale 1ns/1ps
module tb_keypad_scanner;

  logic       clk_in = 1'b0;
  logic       rst_low_in = 1'b0;
  logic [3:0] rows_in, cols_out, key_code_out;
  logic       key_valid_out, key_ready_in, key_held_out, overrun_out;
`ifdef KEYPAD_RELEASE_EVENT_EN
  logic       key_release_out;
`endif
  logic [15:0] keys = '0;

  always #5 clk_in = ~clk_in;

  keypad_scanner #(
    .ROWS(4), .COLS(4), .CLK_PERIOD(10), .SCAN_RATE(10000000), .DEBOUNCE_FRAMES(4), .KEY_W(4)
  ) dut (
    .clk_in(clk_in), .rst_low_in(rst_low_in), .rows_in(rows_in), .cols_out(cols_out),
    .key_code_out(key_code_out), .key_valid_out(key_valid_out), .key_ready_in(key_ready_in),
    .key_held_out(key_held_out), .overrun_out(overrun_out)
`ifdef KEYPAD_RELEASE_EVENT_EN
    , .key_release_out(key_release_out)
`endif
  );

  // Passive matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    rows_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && !cols_out[c]) rows_in[r] = 1'b0;
  end

  typedef struct { logic [3:0] code; logic rel; } ev_t;
  typedef struct { logic [15:0] keys; logic [3:0] code; bit ev; } vec_t;

  ev_t  sb[$];
  vec_t vecs[6];
  int   checks = 0, failures = 0, ev_count = 0, ov_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input logic [3:0] c, input logic r);
    ev_t e;
    e.code = c;
    e.rel  = r;
    sb.push_back(e);
  endtask

  task automatic drive_keys(input logic [15:0] k);
    @(posedge clk_in);
    #1 keys = k;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_valid(input int budget, output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    while (lat < budget && !ok) begin
      @(negedge clk_in);
      lat++;
      if (key_valid_out) ok = 1'b1;
    end
  endtask

  always @(negedge clk_in) begin
    ev_t e;
    if (rst_low_in && key_valid_out && key_ready_in) begin
      ev_count++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: code %0d with empty scoreboard at %0t", key_code_out, $time);
      end else begin
        e = sb.pop_front();
        check("event_code", key_code_out, e.code);
`ifdef KEYPAD_RELEASE_EVENT_EN
        check("event_release", key_release_out, e.rel);
`endif
      end
    end
  end

  always @(negedge clk_in) if (rst_low_in && overrun_out) ov_count++;

  initial begin
    int lat, ov0, ev0, exp_ov;
    bit ok;
    logic [3:0] exp_cols;

    vecs[0] = '{keys: 16'h0200, code: 4'd9,  ev: 1'b1};
    vecs[1] = '{keys: 16'h0001, code: 4'd0,  ev: 1'b1};
    vecs[2] = '{keys: 16'h0021, code: 4'd0,  ev: 1'b0};
    vecs[3] = '{keys: 16'h8000, code: 4'd15, ev: 1'b1};
    vecs[4] = '{keys: 16'h0020, code: 4'd5,  ev: 1'b1};
    vecs[5] = '{keys: 16'h1008, code: 4'd0,  ev: 1'b0};

    key_ready_in = 1'b1;
    idle(3);
    check("rst_cols", cols_out, 4'hF);
    check("rst_code", key_code_out, 0);
    check("rst_valid", key_valid_out, 0);
    check("rst_held", key_held_out, 0);
    check("rst_overrun", overrun_out, 0);
    rst_low_in = 1'b1;

    for (int k = 1; k <= 80; k++) begin
      @(negedge clk_in);
      exp_cols = 4'hF;
      exp_cols[((k - 1) / 10) % 4] = 1'b0;
      check("scan_cols", cols_out, exp_cols);
    end
    check("idle_no_valid", key_valid_out, 0);

    for (int i = 0; i < 6; i++) begin
      ov0 = ov_count;
      ev0 = ev_count;
      if (vecs[i].ev) expect_ev(vecs[i].code, 1'b0);
      drive_keys(vecs[i].keys);
      if (vecs[i].ev) begin
        wait_valid(300, lat, ok);
        check("press_seen", ok, 1);
        check("press_latency_ok", lat <= 204, 1);
        idle(2);
        check("held_pressed", key_held_out, 1);
      end else begin
        idle(250);
        check("multi_no_event", ev_count - ev0, 0);
        check("multi_held", key_held_out, 0);
      end
      check("no_overrun", ov_count - ov0, 0);
`ifdef KEYPAD_RELEASE_EVENT_EN
      if (vecs[i].ev) expect_ev(vecs[i].code, 1'b1);
`endif
      drive_keys('0);
      idle(250);
      check("released_held", key_held_out, 0);
      check("sb_drained", sb.size(), 0);
    end

    // Bounce key 9 for ~100 clocks, then hold it.
    ev0 = ev_count;
    expect_ev(4'd9, 1'b0);
    for (int t = 0; t < 7; t++) begin
      drive_keys(t[0] ? 16'h0000 : 16'h0200);
      repeat (14) @(posedge clk_in);
    end
    check("bounce_no_early_event", ev_count - ev0, 0);
    drive_keys(16'h0200);
    wait_valid(300, lat, ok);
    check("bounce_event_seen", ok, 1);
    idle(250);
    check("bounce_one_event", ev_count - ev0, 1);
`ifdef KEYPAD_RELEASE_EVENT_EN
    expect_ev(4'd9, 1'b1);
`endif
    drive_keys('0);
    idle(250);
    check("bounce_sb_drained", sb.size(), 0);

    // Pending event blocks later ones and raises overrun.
    drive_keys('0);
    key_ready_in = 1'b0;
    ov0 = ov_count;
    exp_ov = 1;
`ifdef KEYPAD_RELEASE_EVENT_EN
    exp_ov = 2;
`endif
    expect_ev(4'd3, 1'b0);
    drive_keys(16'h0008);
    wait_valid(300, lat, ok);
    check("pend_seen", ok, 1);
    check("pend_code", key_code_out, 3);
    drive_keys('0);
    idle(250);
    drive_keys(16'h0010);
    idle(250);
    check("pend_valid_held", key_valid_out, 1);
    check("pend_code_stable", key_code_out, 3);
    check("overrun_pulses", ov_count - ov0, exp_ov);
    @(posedge clk_in);
    #1 key_ready_in = 1'b1;
    idle(2);
    check("valid_clears", key_valid_out, 0);
`ifdef KEYPAD_RELEASE_EVENT_EN
    expect_ev(4'd4, 1'b1);
`endif
    drive_keys('0);
    idle(250);
    check("pend_sb_drained", sb.size(), 0);

    // Asynchronous reset with an event pending; the event is lost.
    drive_keys('0);
    key_ready_in = 1'b0;
    drive_keys(16'h0040);
    wait_valid(300, lat, ok);
    check("pre_reset_valid", ok, 1);
    @(posedge clk_in);
    #3 rst_low_in = 1'b0;
    #1;
    check("arst_cols", cols_out, 4'hF);
    check("arst_code", key_code_out, 0);
    check("arst_valid", key_valid_out, 0);
    check("arst_held", key_held_out, 0);
    check("arst_overrun", overrun_out, 0);
`ifdef KEYPAD_RELEASE_EVENT_EN
    check("arst_release", key_release_out, 0);
`endif
    keys = '0;
    key_ready_in = 1'b1;
    #23 rst_low_in = 1'b1;
    idle(50);

    expect_ev(4'd6, 1'b0);
    drive_keys(16'h0040);
    wait_valid(300, lat, ok);
    check("post_reset_press", ok, 1);
`ifdef KEYPAD_RELEASE_EVENT_EN
    expect_ev(4'd6, 1'b1);
`endif
    drive_keys('0);
    idle(250);
    check("post_reset_held", key_held_out, 0);
    check("final_sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
